// File: rtl/gain_apply.sv
// Programmable output gain stage: converts four BCD digits to a per-mille gain,
// ramps the applied gain toward it and scales the 48 kHz stream with 16-bit saturation.
module gain_apply #(
  parameter int STEP = 1
) (
  input  logic               clk_48,
  input  logic               reset_n,
  input  logic               load,
  input  logic [3:0]         num3,
  input  logic [3:0]         num2,
  input  logic [3:0]         num1,
  input  logic [3:0]         num0,
  input  logic signed [15:0] inWave,
  output logic signed [15:0] outWave,
  output logic [13:0]        gain,
  output logic               busy,
  output logic               err
);

  localparam logic [13:0] STEP_W = 14'(STEP);
  localparam logic [13:0] UNITY  = 14'd1000;

  typedef enum logic {IDLE, CONV} state_t;

  state_t             state_reg;
  logic [3:0]         num_in [4];
  logic [3:0]         digit_reg [4];
  logic [3:0]         digit_bad;
  logic [13:0]        acc_reg;
  logic [13:0]        acc_next;
  logic [1:0]         idx_reg;
  logic [13:0]        target_reg;
  logic [13:0]        gain_reg;
  logic [13:0]        gain_next;
  logic [13:0]        up_gap;
  logic [13:0]        down_gap;
  logic               busy_reg;
  logic               err_reg;
  logic signed [15:0] out_reg;
  logic signed [15:0] out_next;
  logic signed [31:0] wave_ext;
  logic signed [31:0] gain_ext;
  logic signed [31:0] prod;
  logic signed [31:0] quot;

  assign num_in[3] = num3;
  assign num_in[2] = num2;
  assign num_in[1] = num1;
  assign num_in[0] = num0;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit_check
      assign digit_bad[gi] = (num_in[gi] > 4'd9);
    end
  endgenerate

  // acc never exceeds 999 before the last multiply, so 14 bits cannot wrap.
  assign acc_next = acc_reg * 14'd10 + {10'd0, digit_reg[idx_reg]};

  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      for (int i = 0; i < 4; i++) digit_reg[i] <= 4'd0;
      acc_reg    <= 14'd0;
      idx_reg    <= 2'd0;
      target_reg <= UNITY;
      busy_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (load) begin
            for (int i = 0; i < 4; i++) digit_reg[i] <= num_in[i];
            if (|digit_bad) begin
              err_reg <= 1'b1;
            end else begin
              err_reg   <= 1'b0;
              acc_reg   <= 14'd0;
              idx_reg   <= 2'd3;
              busy_reg  <= 1'b1;
              state_reg <= CONV;
            end
          end
        end
        CONV: begin
          acc_reg <= acc_next;
          idx_reg <= idx_reg - 2'd1;
          if (idx_reg == 2'd0) begin
            target_reg <= acc_next;
            busy_reg   <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Slew-limited approach to the target; the step is clipped so it never overshoots.
  always_comb begin
    up_gap    = target_reg - gain_reg;
    down_gap  = gain_reg - target_reg;
    gain_next = gain_reg;
    if (gain_reg < target_reg) begin
      gain_next = gain_reg + ((up_gap > STEP_W) ? STEP_W : up_gap);
    end else if (gain_reg > target_reg) begin
      gain_next = gain_reg - ((down_gap > STEP_W) ? STEP_W : down_gap);
    end
  end

  always_comb begin
    wave_ext = {{16{inWave[15]}}, inWave};
    gain_ext = {18'd0, gain_reg};
    prod     = wave_ext * gain_ext;
    quot     = prod / 32'sd1000;
    if (quot > 32'sd32767) begin
      out_next = 16'sh7FFF;
    end else if (quot < -32'sd32768) begin
      out_next = 16'sh8000;
    end else begin
      out_next = quot[15:0];
    end
  end

  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      gain_reg <= UNITY;
      out_reg  <= 16'sd0;
    end else begin
      gain_reg <= gain_next;
      out_reg  <= out_next;
    end
  end

  assign outWave = out_reg;
  assign gain    = gain_reg;
  assign busy    = busy_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_gain_apply.sv
// Bench for gain_apply: two instances (slow and instant ramp) checked against
// a per-sample behavioural model plus hand-derived expectations.
module tb_gain_apply;

  localparam int STEP_A = 1;
  localparam int STEP_B = 16383;

  logic               clk_48 = 1'b0;
  logic               reset_n = 1'b0;
  logic               load = 1'b0;
  logic [3:0]         n3 = 4'd0, n2 = 4'd0, n1 = 4'd0, n0 = 4'd0;
  logic signed [15:0] in_wave = 16'sd0;
  logic signed [15:0] out_w [2];
  logic [13:0]        gain_w [2];
  logic               busy_w [2];
  logic               err_w [2];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk_48 = ~clk_48;

  gain_apply #(.STEP(STEP_A)) dut_a (
    .clk_48(clk_48), .reset_n(reset_n), .load(load),
    .num3(n3), .num2(n2), .num1(n1), .num0(n0),
    .inWave(in_wave), .outWave(out_w[0]), .gain(gain_w[0]),
    .busy(busy_w[0]), .err(err_w[0])
  );

  gain_apply #(.STEP(STEP_B)) dut_b (
    .clk_48(clk_48), .reset_n(reset_n), .load(load),
    .num3(n3), .num2(n2), .num1(n1), .num0(n0),
    .inWave(in_wave), .outWave(out_w[1]), .gain(gain_w[1]),
    .busy(busy_w[1]), .err(err_w[1])
  );

  // Behavioural model: value-level view of each instance, updated per sample.
  int     steps [2] = '{STEP_A, STEP_B};
  int     m_gain [2] = '{1000, 1000};
  int     m_target [2] = '{1000, 1000};
  int     m_out [2] = '{0, 0};
  int     m_cnt [2] = '{0, 0};
  int     m_pend [2] = '{0, 0};
  bit     m_busy [2] = '{0, 0};
  bit     m_err [2] = '{0, 0};
  longint mp, mq;
  int     mstep;

  always @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_gain[i] = 1000; m_target[i] = 1000; m_out[i] = 0;
        m_cnt[i] = 0; m_busy[i] = 0; m_err[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        mp = longint'(in_wave) * m_gain[i];
        mq = mp / 1000;
        if (mq > 32767) mq = 32767;
        if (mq < -32768) mq = -32768;
        m_out[i] = int'(mq);
        if (m_gain[i] < m_target[i]) begin
          mstep = m_target[i] - m_gain[i];
          m_gain[i] += (mstep < steps[i]) ? mstep : steps[i];
        end else if (m_gain[i] > m_target[i]) begin
          mstep = m_gain[i] - m_target[i];
          m_gain[i] -= (mstep < steps[i]) ? mstep : steps[i];
        end
        if (m_cnt[i] > 0) begin
          m_cnt[i]--;
          if (m_cnt[i] == 0) begin
            m_target[i] = m_pend[i];
            m_busy[i] = 0;
          end
        end else if (load) begin
          if (n3 > 9 || n2 > 9 || n1 > 9 || n0 > 9) begin
            m_err[i] = 1;
          end else begin
            m_err[i] = 0;
            m_pend[i] = n3 * 1000 + n2 * 100 + n1 * 10 + n0;
            m_cnt[i] = 4;
            m_busy[i] = 1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_48);
    @(negedge clk_48);
  endtask

  task automatic set_digits(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
    n3 = a; n2 = b; n1 = c; n0 = d;
  endtask

  task automatic test_reset();
    in_wave = 16'sd1234;
    repeat (2) tick();
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if (out_w[i] !== 16'sd0)
        $display("FAIL reset_out dut%0d: got %0d expected 0", i, out_w[i]);
      else pass_cnt++;
    end
    reset_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        total_cnt++;
        if (out_w[i] !== 16'sd1234 || gain_w[i] !== 14'd1000 || busy_w[i] !== 1'b0 || err_w[i] !== 1'b0)
          $display("FAIL reset_state dut%0d: out=%0d gain=%0d busy=%b err=%b expected 1234/1000/0/0",
                   i, out_w[i], gain_w[i], busy_w[i], err_w[i]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_ramp_down();
    int bc;
    int edges;
    set_digits(4'd0, 4'd5, 4'd0, 4'd0);
    load = 1'b1;
    tick();
    load = 1'b0;
    bc = 0;
    for (int k = 0; k < 8; k++) begin
      if (busy_w[0] === 1'b1) bc++;
      tick();
    end
    total_cnt++;
    if (bc != 4) $display("FAIL busy_len: got %0d cycles expected 4", bc);
    else pass_cnt++;
    edges = 4;
    while (gain_w[0] !== 14'd500 && edges < 600) begin
      in_wave = 16'($urandom);
      tick();
      edges++;
      for (int i = 0; i < 2; i++) begin
        total_cnt++;
        if (out_w[i] !== 16'(m_out[i]) || gain_w[i] !== 14'(m_gain[i]))
          $display("FAIL ramp_model dut%0d: out=%0d gain=%0d expected %0d/%0d",
                   i, out_w[i], gain_w[i], m_out[i], m_gain[i]);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (edges != 500) $display("FAIL ramp_edges: got %0d expected 500", edges);
    else pass_cnt++;
    repeat (3) tick();
    total_cnt++;
    if (gain_w[0] !== 14'd500 || gain_w[1] !== 14'd500)
      $display("FAIL ramp_hold: got %0d/%0d expected 500/500", gain_w[0], gain_w[1]);
    else pass_cnt++;
    in_wave = -16'sd1001;
    tick();
    total_cnt++;
    if (out_w[0] !== -16'sd500 || out_w[1] !== -16'sd500)
      $display("FAIL trunc_neg: got %0d/%0d expected -500", out_w[0], out_w[1]);
    else pass_cnt++;
    in_wave = 16'sd3;
    tick();
    total_cnt++;
    if (out_w[0] !== 16'sd1 || out_w[1] !== 16'sd1)
      $display("FAIL trunc_pos: got %0d/%0d expected 1", out_w[0], out_w[1]);
    else pass_cnt++;
  endtask

  task automatic test_max();
    set_digits(4'd9, 4'd9, 4'd9, 4'd9);
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (4) tick();
    total_cnt++;
    if (gain_w[1] !== 14'd500) $display("FAIL max_pre: got %0d expected 500", gain_w[1]);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (gain_w[1] !== 14'd9999) $display("FAIL max_gain: got %0d expected 9999", gain_w[1]);
    else pass_cnt++;
    in_wave = 16'sd32767;
    tick();
    total_cnt++;
    if (out_w[1] !== 16'sd32767) $display("FAIL sat_pos: got %0d expected 32767", out_w[1]);
    else pass_cnt++;
    in_wave = -16'sd32768;
    tick();
    total_cnt++;
    if (out_w[1] !== -16'sd32768) $display("FAIL sat_neg: got %0d expected -32768", out_w[1]);
    else pass_cnt++;
    in_wave = 16'sd3;
    tick();
    total_cnt++;
    if (out_w[1] !== 16'sd29) $display("FAIL max_small: got %0d expected 29", out_w[1]);
    else pass_cnt++;
  endtask

  task automatic test_bad_digit();
    set_digits(4'd1, 4'd2, 4'hA, 4'd4);
    load = 1'b1;
    tick();
    load = 1'b0;
    total_cnt++;
    if (err_w[0] !== 1'b1 || err_w[1] !== 1'b1)
      $display("FAIL bad_err: got %b/%b expected 1", err_w[0], err_w[1]);
    else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      total_cnt++;
      if (busy_w[1] !== 1'b0 || gain_w[1] !== 14'd9999 || err_w[1] !== 1'b1)
        $display("FAIL bad_hold: busy=%b gain=%0d err=%b expected 0/9999/1", busy_w[1], gain_w[1], err_w[1]);
      else pass_cnt++;
      tick();
    end
    set_digits(4'd1, 4'd0, 4'd0, 4'd0);
    load = 1'b1;
    tick();
    load = 1'b0;
    total_cnt++;
    if (err_w[1] !== 1'b0 || busy_w[1] !== 1'b1)
      $display("FAIL good_after_bad: err=%b busy=%b expected 0/1", err_w[1], busy_w[1]);
    else pass_cnt++;
    repeat (5) tick();
    total_cnt++;
    if (gain_w[1] !== 14'd1000) $display("FAIL bad_recover: got %0d expected 1000", gain_w[1]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    set_digits(4'd9, 4'd9, 4'd9, 4'd9);
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    total_cnt++;
    if (busy_w[1] !== 1'b1) $display("FAIL b2b_busy_e3: got %b expected 1", busy_w[1]);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (busy_w[1] !== 1'b0) $display("FAIL b2b_busy_e4: got %b expected 0", busy_w[1]);
    else pass_cnt++;
    load = 1'b1;
    tick();
    load = 1'b0;
    total_cnt++;
    if (busy_w[1] !== 1'b1 || gain_w[1] !== 14'd1234)
      $display("FAIL b2b_e5: busy=%b gain=%0d expected 1/1234", busy_w[1], gain_w[1]);
    else pass_cnt++;
    repeat (5) tick();
    total_cnt++;
    if (gain_w[1] !== 14'd9999) $display("FAIL b2b_second: got %0d expected 9999", gain_w[1]);
    else pass_cnt++;
  endtask

  task automatic test_random_stream();
    for (int c = 0; c < 300; c++) begin
      in_wave = 16'($urandom);
      load = ($urandom_range(0, 7) == 0);
      set_digits(4'($urandom_range(0, 11)), 4'($urandom_range(0, 10)),
                 4'($urandom_range(0, 10)), 4'($urandom_range(0, 10)));
      tick();
      for (int i = 0; i < 2; i++) begin
        total_cnt++;
        if (out_w[i] !== 16'(m_out[i]) || gain_w[i] !== 14'(m_gain[i]) ||
            busy_w[i] !== m_busy[i] || err_w[i] !== m_err[i])
          $display("FAIL stream dut%0d cyc%0d: out=%0d gain=%0d busy=%b err=%b expected %0d/%0d/%b/%b",
                   i, c, out_w[i], gain_w[i], busy_w[i], err_w[i], m_out[i], m_gain[i], m_busy[i], m_err[i]);
        else pass_cnt++;
      end
    end
    load = 1'b0;
  endtask

  task automatic test_reset_midconv();
    repeat (6) tick();
    set_digits(4'd1, 4'd0, 4'd0, 4'd0);
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (6) tick();
    in_wave = 16'sd5000;
    set_digits(4'd0, 4'd2, 4'd0, 4'd0);
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    @(posedge clk_48);
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if (busy_w[i] !== 1'b0 || gain_w[i] !== 14'd1000 || out_w[i] !== 16'sd0)
        $display("FAIL midconv_reset dut%0d: busy=%b gain=%0d out=%0d expected 0/1000/0",
                 i, busy_w[i], gain_w[i], out_w[i]);
      else pass_cnt++;
    end
    @(negedge clk_48);
    reset_n = 1'b1;
    repeat (10) tick();
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if (gain_w[i] !== 14'd1000 || busy_w[i] !== 1'b0 || out_w[i] !== 16'sd5000)
        $display("FAIL midconv_after dut%0d: gain=%0d busy=%b out=%0d expected 1000/0/5000",
                 i, gain_w[i], busy_w[i], out_w[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    @(negedge clk_48);
    test_reset();
    test_ramp_down();
    test_max();
    test_bad_digit();
    test_back_to_back();
    test_random_stream();
    test_reset_midconv();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/gain_apply.md
# gain_apply

Programmable output gain stage for the channel strip, and the inverse of the output level meter. The meter converts a measured per-mille output/input ratio into four BCD display digits. This block takes four BCD digits from the user, converts them to a binary per-mille gain, and applies that gain to the 48 kHz audio stream. Gain changes ramp toward the new value to avoid zipper noise, and the result saturates to 16 bits.

## Interface
- STEP, default 1: maximum change of the applied gain per clock (per sample), in per-mille units; legal range 1..16383.
- clk_48  in  1  sample clock, one audio sample per rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- load  in  1  request to capture num3..num0 as a new target gain.
- num3, num2, num1, num0  in  4 each  BCD digits of the target gain in per-mille; num3 is the most significant; range 0000..9999.
- inWave  in  16 signed  input sample.
- outWave  out  16 signed  gained, saturated sample.
- gain  out  14 unsigned  gain currently applied, in per-mille.
- busy  out  1  conversion in progress; load is ignored while high.
- err  out  1  sticky flag: last captured digit set contained a digit greater than 9.

## Operation
- Reset values:
  - outWave = 0, gain = 1000 (unity), target = 1000.
  - busy = 0, err = 0, FSM = IDLE, digit registers = 0, accumulator = 0.
- FSM states: IDLE and CONV.
- IDLE, load = 1 at an edge:
  - Register num3..num0.
  - If any digit > 9: err <= 1, stay in IDLE, busy stays 0, target unchanged.
  - Otherwise: err <= 0, acc <= 0, digit index <= 3, busy <= 1, go to CONV.
- CONV: one digit per edge, most significant first: acc <= acc*10 + digit[index].
  - After the num0 step, target <= final acc, busy <= 0, FSM returns to IDLE.
- load in CONV is ignored and not queued.
- Input digits may change after capture without affecting the result.
- Gain ramp, every edge, in every state:
  - If gain < target: gain <= gain + min(STEP, target − gain).
  - If gain > target: gain <= gain − min(STEP, gain − target).
  - Gain never overshoots target.
- Arithmetic, every edge:
  - Form the 32-bit signed product p = inWave × gain, using gain before this edge's ramp update, zero-extended.
  - Compute q = p / 1000, truncated toward zero.
  - outWave <= q clamped to [−32768, 32767].
- Intermediate widths:
  - acc is 14 bits; maximum value 9999 fits.
  - Product magnitude ≤ 32768 × 9999 < 2^31, so there is no overflow before the clamp.
- Reset mid-conversion discards the conversion and returns every register to its reset value immediately (asynchronous).

## Timing
- Let E0 be the edge that samples load = 1 in IDLE with valid digits.
  - busy is high after E0 through E4.
  - Digit steps occur at E1..E4.
  - target is updated at E4.
  - busy falls after E4.
  - The earliest new load is sampled at E5.
- Ramp: gain starts moving at E5.
  - gain equals target after ceil(|target − gain| / STEP) further edges.
- Datapath latency: 1 clock from inWave to outWave, with no throughput loss.
  - outWave at edge n reflects inWave and gain as they stood before edge n.
- err updates at the capture edge E0 and holds until the next accepted load.

## Test plan
- Reset, then hold inWave = 1234 for 2 cycles → gain = 1000, busy = 0, err = 0, outWave = 1234 one cycle after inWave is applied; outWave = 0 while reset_n is low.
- STEP = 1, load digits 0,5,0,0 → busy high for exactly 4 cycles, gain reaches 500 exactly 500 edges after E4 and stays; then inWave = −1001 → outWave = −500 (truncated toward zero); inWave = 3 → outWave = 1.
- STEP = 16383, load 9,9,9,9 → gain = 9999 one edge after E4; inWave = 32767 → outWave = 32767; inWave = −32768 → outWave = −32768; inWave = 3 → outWave = 29.
- Load digits 1,2,A,4 → err = 1, busy never rises, gain and target unchanged; then load 1,0,0,0 → err = 0 after capture, target = 1000.
- Load 1,2,3,4 at E0, change digits to 9,9,9,9 and pulse load at E2 → target = 1234, busy falls after E4, second load has no effect; a load sampled at E5 is accepted.
- Load 0,2,0,0 from gain 1000 and assert reset_n = 0 at E2 → busy = 0, gain = 1000, target = 1000, outWave = 0 immediately; no later ramp toward 200.
